// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM state encoding, instruction width, NOP word and FIFO entry layout.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_ent_t;

  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] a);
    return a & ~INST_W'(3);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH x {pc,inst} sync FIFO with flush; head is registered, so a push into an empty FIFO
// shows on head_o the next cycle. Flush wins over push/pop; a push while full is accepted only alongside a pop.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           push_i,
  input  fetch_ent_t     wdata_i,
  input  logic           pop_i,
  input  logic           flush_i,
  output fetch_ent_t     head_o,
  output logic [PTR_W:0] count_o,
  output logic           empty_o
);

  fetch_ent_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  fetch_ent_t       head_q, head_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Next head comes from storage at the new read pointer, or straight from the
  // write data when that slot is being filled this same cycle.
  always_comb begin
    head_d = '{pc: '0, inst: NOP_WORD};
    if (count_d != '0) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) head_d = wdata_i;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '{pc: '0, inst: NOP_WORD};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_buf.sv
// Fetch stage: single-outstanding imem requests from pc, buffered to decode; ack-to-id_valid 1 cycle,
// issue parks in IDLE while the FIFO is full. Build with IFETCH_PERF_EN for perf_fetch/perf_stall counters.
module ifetch_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [INST_W-1:0] pc,
  output logic              pc_adv,
  output logic              imem_req,
  output logic [INST_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [INST_W-1:0] id_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_stall
`endif
);

  if_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic [INST_W-1:0] addr_q, addr_d;
  logic              adv_q, adv_d;
  logic              push;
  logic              issue_ok;
  logic [PTR_W:0]    count;
  logic              empty;
  fetch_ent_t        wr_ent;
  fetch_ent_t        head;

  // While pc_adv is out the PC register has not yet loaded the next PC, so the
  // completed-but-unadvanced fetch counts as pending and holds off issue.
  assign issue_ok = !redirect && !adv_q && (int'(count) < DEPTH);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IF_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_IDLE: if (issue_ok) state_d = IF_WAIT;
      IF_WAIT: begin
        if (imem_ack)      state_d = IF_IDLE;
        else if (redirect) state_d = IF_DROP;
      end
      IF_DROP: if (imem_ack) state_d = IF_IDLE;
      default: state_d = IF_IDLE;
    endcase
  end

  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    adv_d  = 1'b0;
    push   = 1'b0;
    unique case (state_q)
      IF_IDLE: begin
        if (issue_ok) begin
          req_d  = 1'b1;
          addr_d = word_align(pc);
        end
      end
      IF_WAIT: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (!redirect) begin
            push  = 1'b1;
            adv_d = 1'b1;
          end
        end
      end
      IF_DROP: if (imem_ack) req_d = 1'b0;
      default: req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      adv_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      adv_q  <= adv_d;
    end
  end

  assign wr_ent = '{pc: addr_q, inst: imem_rdata};

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push_i  (push),
    .wdata_i (wr_ent),
    .pop_i   (id_ready),
    .flush_i (redirect),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  assign pc_adv    = adv_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = !empty;
  assign id_inst   = head.inst;
  assign id_pc     = head.pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push)              perf_fetch_q <= perf_fetch_q + 32'd1;
      if (id_ready && empty) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf: a behavioural PC register and imem model drive the DUT;
// expected addresses, pulses and FIFO contents are hand-computed per scenario.
module tb_ifetch_buf;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_adv;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  ifetch_buf dut (
    .clk        (clk),
    .clrn       (clrn),
    .pc         (pc),
    .pc_adv     (pc_adv),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] fetch_q [$];
  logic [31:0] pop_pc [$];
  logic [31:0] pop_inst [$];
  int          adv_cnt = 0;
  int          lat_cnt = 0;
  int          mem_lat = 0;
  bit          mem_auto = 1'b0;
  bit          pc_follow = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : (32'h1000_0000 | a);
  endfunction

  // One clock: log what the DUT shows this cycle, cross the edge, then play PC register and memory.
  task automatic tick();
    logic adv_now;
    adv_now = pc_adv;
    if (id_valid && id_ready) begin
      pop_pc.push_back(id_pc);
      pop_inst.push_back(id_inst);
    end
    if (imem_req && imem_ack && !redirect) fetch_q.push_back(imem_addr);
    if (pc_adv) adv_cnt++;
    @(posedge clk);
    #1;
    if (adv_now && pc_follow) pc = pc + 32'd4;
    if (mem_auto) begin
      if (imem_ack) imem_ack = 1'b0;
      else if (imem_req) begin
        if (lat_cnt == mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = inst_of(imem_addr);
          lat_cnt    = 0;
        end else lat_cnt++;
      end
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc, input logic rdy, input bit check_rst);
    clrn = 1'b0; redirect = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    pc = start_pc; id_ready = rdy;
    fetch_q.delete(); pop_pc.delete(); pop_inst.delete();
    adv_cnt = 0; lat_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    if (check_rst) begin
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_adv", {31'b0, pc_adv}, 32'd0);
      chk("rst_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_inst", id_inst, 32'd0);
      chk("rst_pc", id_pc, 32'd0);
    end
    #2 clrn = 1'b1;
  endtask

  task automatic wait_fetches(input int n, input int budget);
    int k;
    k = 0;
    while (fetch_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_fetches", fetch_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic fetch with memory acking in the first WAIT cycle
    mem_auto = 1'b1; mem_lat = 0; pc_follow = 1'b1;
    do_reset(32'h0, 1'b1, 1'b1);
    tick();
    chk("t1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_valid0", {31'b0, id_valid}, 32'd0);
    tick();
    chk("t1_adv", {31'b0, pc_adv}, 32'd1);
    chk("t1_valid", {31'b0, id_valid}, 32'd1);
    chk("t1_inst", id_inst, 32'h2008_0005);
    chk("t1_pc", id_pc, 32'h0);
    chk("t1_req_drop", {31'b0, imem_req}, 32'd0);
    tick();
    chk("t1_adv_once", {31'b0, pc_adv}, 32'd0);
    chk("t1_popped", {31'b0, id_valid}, 32'd0);
    tick();
    chk("t1_req2", {31'b0, imem_req}, 32'd1);
    chk("t1_addr2", imem_addr, 32'h4);

    // Back-pressure fills the FIFO, then drains in order and resumes at 0x10
    mem_lat = 1;
    do_reset(32'h0, 1'b0, 1'b0);
    repeat (40) tick();
    chk("t2_nfetch", fetch_q.size(), 4);
    chk("t2_f3", fetch_q[3], 32'hC);
    chk("t2_parked", {31'b0, imem_req}, 32'd0);
    chk("t2_advs", adv_cnt, 4);
    chk("t2_pc", pc, 32'h10);
    chk("t2_head", id_pc, 32'h0);
    id_ready = 1'b1;
    repeat (40) tick();
    chk("t2_npop", {31'b0, pop_pc.size() >= 5}, 32'd1);
    for (int i = 0; i < 4; i++) chk("t2_order", pop_pc[i], 32'(4 * i));
    chk("t2_inst0", pop_inst[0], 32'h2008_0005);
    chk("t2_resume", fetch_q[4], 32'h10);
    chk("t2_pop4", pop_pc[4], 32'h10);
    chk("t2_inst4", pop_inst[4], 32'h1000_0010);

    // Redirect while waiting: DROP swallows the late ack
    mem_auto = 1'b0;
    do_reset(32'h0, 1'b0, 1'b0);
    tick();
    chk("t3_req", {31'b0, imem_req}, 32'd1);
    redirect = 1'b1;
    tick();
    redirect = 1'b0; pc = 32'h40;
    chk("t3_hold_req", {31'b0, imem_req}, 32'd1);
    tick();
    tick();
    chk("t3_addr_stable", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("t3_req_drop", {31'b0, imem_req}, 32'd0);
    chk("t3_no_adv", {31'b0, pc_adv}, 32'd0);
    chk("t3_empty", {31'b0, id_valid}, 32'd0);
    tick();
    chk("t3_newreq", {31'b0, imem_req}, 32'd1);
    chk("t3_newaddr", imem_addr, 32'h40);
    chk("t3_advs", adv_cnt, 0);

    // Redirect and ack together with two entries buffered
    mem_auto = 1'b1; mem_lat = 0;
    do_reset(32'h0, 1'b0, 1'b0);
    wait_fetches(2, 30);
    mem_auto = 1'b0;
    for (int k = 0; k < 10 && !imem_req; k++) tick();
    chk("t4_addr", imem_addr, 32'h8);
    chk("t4_valid", {31'b0, id_valid}, 32'd1);
    chk("t4_head", id_pc, 32'h0);
    redirect = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    redirect = 1'b0; imem_ack = 1'b0; pc = 32'h80;
    chk("t4_flush", {31'b0, id_valid}, 32'd0);
    chk("t4_no_adv", {31'b0, pc_adv}, 32'd0);
    chk("t4_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("t4_no_adv2", {31'b0, pc_adv}, 32'd0);
    chk("t4_newaddr", imem_addr, 32'h80);

    // Asynchronous reset mid-WAIT
    do_reset(32'h100, 1'b1, 1'b0);
    tick();
    chk("t5_addr", imem_addr, 32'h100);
    #2 clrn = 1'b0;
    #1;
    chk("t5_req0", {31'b0, imem_req}, 32'd0);
    chk("t5_addr0", imem_addr, 32'h0);
    chk("t5_valid0", {31'b0, id_valid}, 32'd0);
    #1 pc = 32'h200; clrn = 1'b1;
    tick();
    chk("t5_restart_req", {31'b0, imem_req}, 32'd1);
    chk("t5_restart_addr", imem_addr, 32'h200);

`ifdef IFETCH_PERF_EN
    mem_auto = 1'b1; mem_lat = 0;
    do_reset(32'h0, 1'b0, 1'b0);
    wait_fetches(3, 40);
    mem_auto = 1'b0;
    id_ready = 1'b1;
    repeat (8) tick();
    id_ready = 1'b0;
    chk("t6_fetch", perf_fetch, 32'd3);
    chk("t6_stall", perf_stall, 32'd5);
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    chk("t6_fetch_kept", perf_fetch, 32'd3);
    chk("t6_stall_kept", perf_stall, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
